// File: rtl/led_panel_frame_buffer.sv
// Double-buffered RGB frame store for the LED panel scan engine; banks swap only on a v_sync rising edge.
// Define LED_PANEL_DOUBLE_BUFFER_EN for two banks; otherwise a single bank is shared by host and panel.
module led_panel_frame_buffer #(
  parameter int COLOR_BITS         = 8,
  parameter int DISPLAY_ROWS_LINES = 4,
  parameter int DISPLAY_COLS_LINES = 6
) (
  input  logic                                           CLK,
  input  logic                                           RST,
  input  logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES:0]   memAddrIn,
  input  logic [3*COLOR_BITS-1:0]                        memDataIn,
  input  logic                                           memWrite,
  input  logic                                           swap_req,
  output logic                                           swap_ack,
  output logic                                           front_bank,
  input  logic                                           v_sync,
  input  logic [DISPLAY_ROWS_LINES+DISPLAY_COLS_LINES-1:0] memAddrMst,
  input  logic [$clog2(COLOR_BITS)-1:0]                  bitplaneMst,
  output logic                                           R0,
  output logic                                           G0,
  output logic                                           B0,
  output logic                                           R1,
  output logic                                           G1,
  output logic                                           B1
);

  localparam int AW    = DISPLAY_ROWS_LINES + DISPLAY_COLS_LINES;
  localparam int PW    = $clog2(COLOR_BITS);
  localparam int CW    = COLOR_BITS;
  localparam int DEPTH = 1 << AW;

  logic [3*CW-1:0] mem_up0 [DEPTH];
  logic [3*CW-1:0] mem_lo0 [DEPTH];
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
  logic [3*CW-1:0] mem_up1 [DEPTH];
  logic [3*CW-1:0] mem_lo1 [DEPTH];
  logic            front_q, front_d;
  logic            rbank_q, rbank_d;
`endif

  logic [AW-1:0]   raddr_q, raddr_d;
  logic [PW-1:0]   plane_q, plane_d;
  logic            vs_prev_q, vs_prev_d;
  logic            pending_q, pending_d;
  logic            ack_q, ack_d;
  logic [5:0]      out_q, out_d;

  logic            vs_rise;
  logic            do_swap;
  logic [AW-1:0]   waddr;
  logic [3*CW-1:0] word_up, word_lo;
  logic [CW-1:0]   r_up, g_up, b_up, r_lo, g_lo, b_lo;

  assign waddr = memAddrIn[AW-1:0];

  always_comb begin
    vs_rise   = v_sync & ~vs_prev_q;
    // A request arriving on the swap edge itself is consumed by that swap.
    do_swap   = vs_rise & (pending_q | swap_req);
    pending_d = ~do_swap & (pending_q | swap_req);
    vs_prev_d = v_sync;
    ack_d     = do_swap;
    raddr_d   = memAddrMst;
    plane_d   = bitplaneMst;
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
    front_d   = front_q ^ do_swap;
    rbank_d   = front_q;
    word_up   = rbank_q ? mem_up1[raddr_q] : mem_up0[raddr_q];
    word_lo   = rbank_q ? mem_lo1[raddr_q] : mem_lo0[raddr_q];
`else
    word_up   = mem_up0[raddr_q];
    word_lo   = mem_lo0[raddr_q];
`endif
    {r_up, g_up, b_up} = word_up;
    {r_lo, g_lo, b_lo} = word_lo;
    out_d = {r_up[plane_q], g_up[plane_q], b_up[plane_q],
             r_lo[plane_q], g_lo[plane_q], b_lo[plane_q]};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      raddr_q   <= '0;
      plane_q   <= '0;
      vs_prev_q <= 1'b0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      out_q     <= '0;
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
      front_q   <= 1'b0;
      rbank_q   <= 1'b0;
`endif
    end else begin
      raddr_q   <= raddr_d;
      plane_q   <= plane_d;
      vs_prev_q <= vs_prev_d;
      pending_q <= pending_d;
      ack_q     <= ack_d;
      out_q     <= out_d;
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
      front_q   <= front_d;
      rbank_q   <= rbank_d;
`endif
    end
  end

  // Host writes always land in the bank not being displayed; contents survive reset.
  always_ff @(posedge CLK) begin
    if (!RST && memWrite) begin
`ifdef LED_PANEL_DOUBLE_BUFFER_EN
      case ({front_q, memAddrIn[AW]})
        2'b00:   mem_up1[waddr] <= memDataIn;
        2'b01:   mem_lo1[waddr] <= memDataIn;
        2'b10:   mem_up0[waddr] <= memDataIn;
        default: mem_lo0[waddr] <= memDataIn;
      endcase
`else
      if (memAddrIn[AW]) mem_lo0[waddr] <= memDataIn;
      else               mem_up0[waddr] <= memDataIn;
`endif
    end
  end

`ifdef LED_PANEL_DOUBLE_BUFFER_EN
  assign front_bank = front_q;
`else
  assign front_bank = 1'b0;
`endif
  assign swap_ack = ack_q;
  assign {R0, G0, B0, R1, G1, B1} = out_q;

endmodule
